// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared types, constants and FSM state encodings for the instruction cache.
package inst_cache_pkg;
    typedef logic [31:0] AddrType;
    typedef logic [31:0] WordType;
    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;
    typedef enum logic [1:0] {
        ICACHE_IDLE,
        ICACHE_MISS_ISSUE,
        ICACHE_MISS_WAIT
    } icache_state_e;
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: tag/data/valid arrays, combinational read, synchronous write.
// Ports: rd_idx_i -> rd_valid_o/rd_tag_o/rd_data_o (combinational lookup);
//        we_i/wr_idx_i/wr_tag_i/wr_data_i (line fill); rst clears every valid bit.
module icache_line_store
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output WordType               rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  WordType               wr_data_i
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];
    WordType             data_q [LINES];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else if (we_i) valid_q[wr_idx_i] <= True;
    end
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped one-word-per-line instruction cache with a single-fetch miss path.
// Ports: clk, rst (sync, active-high), rdy (global stall), clear_flag_in (pipeline clear);
//        fetcher side if_req_in/if_pc_in -> if_valid_out/if_pc_out/if_inst_out;
//        memory side mc_fetch_enable_out/mc_addr_out <- mc_result_enable_in/mc_data_in.
// Define ICACHE_PERF_EN to add hit_count_out/miss_count_out request counters.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear_flag_in,
    input  logic        if_req_in,
    input  logic [31:0] if_pc_in,
    output logic        if_valid_out,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_inst_out,
    output logic        mc_fetch_enable_out,
    output logic [31:0] mc_addr_out,
    input  logic        mc_result_enable_in,
    input  logic [31:0] mc_data_in
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count_out,
    output logic [31:0] miss_count_out
`endif
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    icache_state_e       state_q, state_d;
    AddrType             pc_q, pc_d;
    logic                valid_q, valid_d;
    AddrType             pc_out_q, pc_out_d;
    WordType             inst_q, inst_d;
    logic                fetch_q, fetch_d;
    AddrType             addr_q, addr_d;
    logic                line_we;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    WordType             rd_data;
    logic                hit;
    icache_line_store #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (if_pc_in[INDEX_BITS+1:2]),
        .rd_valid_o(rd_valid),
        .rd_tag_o  (rd_tag),
        .rd_data_o (rd_data),
        .we_i      (line_we),
        .wr_idx_i  (pc_q[INDEX_BITS+1:2]),
        .wr_tag_i  (pc_q[31:INDEX_BITS+2]),
        .wr_data_i (mc_data_in)
    );
    assign hit = rd_valid && (rd_tag == if_pc_in[31:INDEX_BITS+2]);
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = False;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        fetch_d  = False;
        addr_d   = addr_q;
        line_we  = False;
        if (clear_flag_in) begin
            state_d = ICACHE_IDLE;
        end else if (rdy) begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (if_req_in && hit) begin
                        valid_d  = True;
                        pc_out_d = if_pc_in;
                        inst_d   = rd_data;
                    end else if (if_req_in) begin
                        // Fetch pulse and address are registered, so they are set up here
                        // to be visible during the MISS_ISSUE cycle.
                        pc_d    = if_pc_in;
                        fetch_d = True;
                        addr_d  = {if_pc_in[31:2], 2'b00};
                        state_d = ICACHE_MISS_ISSUE;
                    end
                end
                ICACHE_MISS_ISSUE: state_d = ICACHE_MISS_WAIT;
                ICACHE_MISS_WAIT: begin
                    if (mc_result_enable_in) begin
                        line_we  = True;
                        valid_d  = True;
                        pc_out_d = pc_q;
                        inst_d   = mc_data_in;
                        state_d  = ICACHE_IDLE;
                    end
                end
                default: state_d = ICACHE_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ICACHE_IDLE;
            pc_q     <= '0;
            valid_q  <= False;
            pc_out_q <= '0;
            inst_q   <= '0;
            fetch_q  <= False;
            addr_q   <= '0;
        end else if (rdy || clear_flag_in) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            fetch_q  <= fetch_d;
            addr_q   <= addr_d;
        end
    end
    assign if_valid_out        = valid_q;
    assign if_pc_out           = pc_out_q;
    assign if_inst_out         = inst_q;
    assign mc_fetch_enable_out = fetch_q;
    assign mc_addr_out         = addr_q;
`ifdef ICACHE_PERF_EN
    logic    accept;
    AddrType hit_cnt_q, miss_cnt_q;
    assign accept = rdy && !clear_flag_in && (state_q == ICACHE_IDLE) && if_req_in;
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept && hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
        end else if (accept) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;
`endif
endmodule
